// File: rtl/fmap_mem_arbiter.sv
// Two-client arbiter for the feature-map RAM: per-burst ownership with round-robin tie-break,
// (y, x) to linear address translation, and write-to-read forwarding on same-address collisions.
module fmap_mem_arbiter #(
  parameter int unsigned COORD_BITS       = 8,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned BITS_PER_CHANNEL = 8,
  parameter int unsigned IMG_WIDTH        = 32,
  parameter int unsigned IMG_HEIGHT       = 32,
  parameter int unsigned MAX_BURST        = 16,
  localparam int unsigned W               = CHANNELS * BITS_PER_CHANNEL,
  localparam int unsigned ADDR_BITS       = $clog2(IMG_WIDTH * IMG_HEIGHT),
  localparam int unsigned CB              = 2 * COORD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           rd_req,
  input  logic [CB-1:0]        rd_coord [2],
  output logic [1:0]           rd_grant,
  output logic [1:0]           rd_valid,
  output logic [W-1:0]         rd_data [2],
  input  logic [1:0]           wr_req,
  input  logic [CB-1:0]        wr_coord [2],
  input  logic [W-1:0]         wr_data [2],
  output logic [1:0]           wr_grant,
  input  logic [1:0]           lock,
  output logic [1:0]           owner,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic [W-1:0]         mem_rd_data,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [W-1:0]         mem_wr_data,
  output logic                 addr_err
);

  localparam int unsigned HW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q;
  logic            rr_q;
  logic [HW-1:0]   hold_q;
  logic [1:0]      rv_q;
  logic            oor_q;
  logic            byp_q;
  logic [W-1:0]    byp_data_q;
  logic            addr_err_q;

  logic [1:0]      active;
  logic            owning;
  logic            sel;
  logic            rd_ok;
  logic            wr_ok;
  logic            rd_oor;
  logic            wr_oor;
  logic            bypass;
  logic            timeout;
  logic [W-1:0]    ret_data;

  function automatic logic [ADDR_BITS-1:0] to_addr(input logic [CB-1:0] c);
    return ADDR_BITS'(c[CB-1:COORD_BITS]) * ADDR_BITS'(IMG_WIDTH)
         + ADDR_BITS'(c[COORD_BITS-1:0]);
  endfunction

  function automatic logic in_range(input logic [CB-1:0] c);
    return (32'(c[COORD_BITS-1:0]) < IMG_WIDTH) && (32'(c[CB-1:COORD_BITS]) < IMG_HEIGHT);
  endfunction

  assign active = rd_req | wr_req | lock;
  assign owning = (state_q != StIdle);
  assign sel    = (state_q == StOwn1);
  assign owner  = {state_q == StOwn1, state_q == StOwn0};

  always_comb begin
    rd_grant    = '0;
    wr_grant    = '0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    rd_ok       = in_range(rd_coord[sel]);
    wr_ok       = in_range(wr_coord[sel]);
    rd_oor      = 1'b0;
    wr_oor      = 1'b0;
    if (owning) begin
      rd_grant[sel] = rd_req[sel];
      wr_grant[sel] = wr_req[sel];
      // Out-of-range requests are still granted; only the RAM enable is withheld.
      mem_rd_en     = rd_req[sel] & rd_ok;
      mem_rd_addr   = to_addr(rd_coord[sel]);
      mem_wr_en     = wr_req[sel] & wr_ok;
      mem_wr_addr   = to_addr(wr_coord[sel]);
      mem_wr_data   = wr_data[sel];
      rd_oor        = rd_req[sel] & ~rd_ok;
      wr_oor        = wr_req[sel] & ~wr_ok;
    end
  end

  assign bypass  = mem_rd_en & mem_wr_en & (mem_rd_addr == mem_wr_addr);
  assign timeout = ~lock[sel] & active[~sel] & (hold_q >= HW'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hold_q <= '0;
          unique case (active)
            2'b01:   state_q <= StOwn0;
            2'b10:   state_q <= StOwn1;
            2'b11: begin
              state_q <= rr_q ? StOwn1 : StOwn0;
              rr_q    <= ~rr_q;
            end
            default: state_q <= StIdle;
          endcase
        end
        StOwn0, StOwn1: begin
          if (!active[sel] || timeout) begin
            state_q <= StIdle;
          end else if (hold_q < HW'(MAX_BURST - 1)) begin
            // Saturates so a lock dropped after a long burst releases at once.
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q       <= '0;
      oor_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rv_q       <= rd_grant;
      oor_q      <= rd_oor;
      byp_q      <= bypass;
      byp_data_q <= mem_wr_data;
      if (rd_oor || wr_oor) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ret_data = byp_q ? byp_data_q : (oor_q ? '0 : mem_rd_data);
    for (int k = 0; k < 2; k++) begin
      rd_data[k] = rv_q[k] ? ret_data : '0;
    end
  end

  assign rd_valid = rv_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// Directed bench for fmap_mem_arbiter with a behavioural read-before-write RAM.
module tb_fmap_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_req, wr_req, lock;
  logic [15:0] rd_coord [2];
  logic [15:0] wr_coord [2];
  logic [31:0] wr_data [2];
  logic [1:0]  rd_grant, rd_valid, wr_grant, owner;
  logic [31:0] rd_data [2];
  logic        mem_rd_en, mem_wr_en, addr_err;
  logic [9:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic [31:0] ram [1024];

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  fmap_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_coord    (rd_coord),
    .rd_grant    (rd_grant),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_coord    (wr_coord),
    .wr_data     (wr_data),
    .wr_grant    (wr_grant),
    .lock        (lock),
    .owner       (owner),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .addr_err    (addr_err)
  );

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    rd_req = '0;
    wr_req = '0;
    lock   = '0;
    for (int k = 0; k < 2; k++) begin
      rd_coord[k] = '0;
      wr_coord[k] = '0;
      wr_data[k]  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    mem_rd_data = '0;
    clear_inputs();
    cyc();
    cyc();
    settle();
    check("reset_owner", 64'(owner), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_addr_err", 64'(addr_err), 64'd0);
    check("reset_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    reset = 1'b0;

    // Single read at {y=2,x=3} -> address 67
    cyc();
    rd_req[0] = 1'b1;
    rd_coord[0] = {8'd2, 8'd3};
    settle();
    check("idle_no_grant", 64'(rd_grant), 64'd0);
    cyc();
    settle();
    check("single_grant", 64'(rd_grant), 64'b01);
    check("single_mem_rd_en", 64'(mem_rd_en), 64'd1);
    check("single_addr", 64'(mem_rd_addr), 64'd67);
    check("single_owner", 64'(owner), 64'b01);
    cyc();
    rd_req[0] = 1'b0;
    settle();
    check("single_valid", 64'(rd_valid), 64'b01);
    check("single_data0", 64'(rd_data[0]), 64'hC0DE0043);
    check("single_data1_zero", 64'(rd_data[1]), 64'd0);

    // Tie after reset: client 0 first, then client 1, next tie client 1
    do_reset();
    cyc();
    rd_req = 2'b11;
    rd_coord[0] = {8'd2, 8'd3};
    rd_coord[1] = {8'd4, 8'd5};
    settle();
    check("tie_idle", 64'(owner), 64'd0);
    cyc();
    settle();
    check("tie_first_owner", 64'(owner), 64'b01);
    check("tie_first_grant", 64'(rd_grant), 64'b01);
    cyc();
    rd_req[0] = 1'b0;
    settle();
    cyc();
    settle();
    check("tie_release_gap", 64'(owner), 64'd0);
    cyc();
    settle();
    check("tie_c1_owner", 64'(owner), 64'b10);
    check("tie_c1_grant", 64'(rd_grant), 64'b10);
    cyc();
    rd_req[1] = 1'b0;
    settle();
    check("c1_read_valid", 64'(rd_valid), 64'b10);
    check("c1_read_data", 64'(rd_data[1]), 64'hC0DE0085);
    cyc();
    settle();
    cyc();
    rd_req = 2'b11;
    settle();
    cyc();
    settle();
    check("second_tie_c1", 64'(owner), 64'b10);

    // Lock held for 40 cycles never times out
    do_reset();
    cyc();
    rd_req = 2'b11;
    lock[0] = 1'b1;
    settle();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      settle();
      if (owner != 2'b01) cnt++;
    end
    check("lock_no_timeout", 64'(cnt), 64'd0);
    cyc();
    lock[0] = 1'b0;
    settle();
    check("unlock_last_c0", 64'(owner), 64'b01);
    cyc();
    settle();
    check("unlock_gap", 64'(owner), 64'd0);
    cyc();
    settle();
    check("unlock_c1_grant", 64'(rd_grant), 64'b10);

    // Unlocked burst times out after 16 grants
    do_reset();
    cyc();
    rd_req = 2'b11;
    settle();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      settle();
      if (rd_grant == 2'b01) cnt++;
    end
    check("burst_c0_grants", 64'(cnt), 64'd16);
    cyc();
    settle();
    check("timeout_gap", 64'(owner), 64'd0);
    cyc();
    settle();
    check("timeout_c1_grant", 64'(rd_grant), 64'b10);

    // Same-address write and read forward the write data
    do_reset();
    cyc();
    rd_req[0] = 1'b1;
    wr_req[0] = 1'b1;
    rd_coord[0] = {8'd1, 8'd1};
    wr_coord[0] = {8'd1, 8'd1};
    wr_data[0] = 32'hA5A5A5A5;
    settle();
    cyc();
    settle();
    check("byp_wr_grant", 64'(wr_grant), 64'b01);
    check("byp_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'b11);
    check("byp_wr_addr", 64'(mem_wr_addr), 64'd33);
    cyc();
    rd_req = '0;
    wr_req = '0;
    settle();
    check("byp_valid", 64'(rd_valid), 64'b01);
    check("byp_data", 64'(rd_data[0]), 64'hA5A5A5A5);

    // Out-of-range read {y=0,x=32}
    do_reset();
    cyc();
    rd_req[0] = 1'b1;
    rd_coord[0] = 16'h0020;
    settle();
    check("oor_err_before", 64'(addr_err), 64'd0);
    cyc();
    settle();
    check("oor_grant", 64'(rd_grant), 64'b01);
    check("oor_no_mem_rd", 64'(mem_rd_en), 64'd0);
    cyc();
    rd_req = '0;
    settle();
    check("oor_valid", 64'(rd_valid), 64'b01);
    check("oor_data_zero", 64'(rd_data[0]), 64'd0);
    check("oor_err_set", 64'(addr_err), 64'd1);
    repeat (3) cyc();
    settle();
    check("oor_err_sticky", 64'(addr_err), 64'd1);

    // Reset pulsed during a granted read
    do_reset();
    settle();
    check("reset_clears_err", 64'(addr_err), 64'd0);
    cyc();
    rd_req[0] = 1'b1;
    rd_coord[0] = {8'd3, 8'd4};
    settle();
    cyc();
    settle();
    check("mid_grant", 64'(rd_grant), 64'b01);
    reset = 1'b1;
    #1;
    check("async_grant", 64'(rd_grant), 64'd0);
    check("async_owner", 64'(owner), 64'd0);
    check("async_mem", 64'({mem_rd_en, mem_rd_addr}), 64'd0);
    rd_req = '0;
    cyc();
    settle();
    check("no_inflight_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    cyc();
    rd_req[0] = 1'b1;
    settle();
    check("post_reset_idle", 64'(rd_grant), 64'd0);
    cyc();
    settle();
    check("post_reset_grant", 64'(rd_grant), 64'b01);
    cyc();
    rd_req = '0;
    settle();
    check("post_reset_valid", 64'(rd_valid), 64'b01);
    check("post_reset_data", 64'(rd_data[0]), 64'hC0DE0064);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_mem_arbiter.md
# fmap_mem_arbiter

Shares the single feature-map memory (one synchronous read port, one write port, 1-cycle read latency) between two requesters: client 0, the convolution engine's read-modify-write stream, and client 1, the leak/decay sweeper. It grants ownership of the memory per burst with round-robin tie-break, translates (x, y) coordinates to linear addresses, and forwards same-address write data to reads. It sits between the processing modules' `arbiter_if` ports and the feature-map RAM.

## Interface
- COORD_BITS, 8, width of each coordinate component
- CHANNELS, 4, channels per memory word
- BITS_PER_CHANNEL, 8, bits per channel; word width W = CHANNELS*BITS_PER_CHANNEL
- IMG_WIDTH, 32, x extent
- IMG_HEIGHT, 32, y extent; ADDR_BITS = $clog2(IMG_WIDTH*IMG_HEIGHT)
- MAX_BURST, 16, maximum unlocked ownership cycles while the other client waits
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Per client k ∈ {0,1}, all ports indexed [k]:
  - rd_req  in  1  read request
  - rd_coord  in  2*COORD_BITS  read coordinate {y, x}
  - rd_grant  out  1  read accepted this cycle
  - rd_valid  out  1  read data valid
  - rd_data  out  W  read data
  - wr_req  in  1  write request
  - wr_coord  in  2*COORD_BITS  write coordinate {y, x}
  - wr_data  in  W  write data
  - wr_grant  out  1  write accepted this cycle
  - lock  in  1  hold ownership across a burst
  - owner  out  1  client k owns the memory
- mem_rd_en  out  1  RAM read enable
- mem_rd_addr  out  ADDR_BITS  RAM read address
- mem_rd_data  in  W  RAM read data, valid 1 cycle after mem_rd_en
- mem_wr_en  out  1  RAM write enable
- mem_wr_addr  out  ADDR_BITS  RAM write address
- mem_wr_data  out  W  RAM write data
- addr_err  out  1  sticky: an out-of-range coordinate was granted

## Operation
- States: IDLE, OWN0, OWN1. A client is active when rd_req | wr_req | lock.
- IDLE: no grants and no memory enables. If exactly one client is active, go to OWNk. If both are active, go to the client named by the round-robin pointer rr. rr then points to the other client.
- OWNk: rd_grant[k] = rd_req[k] and wr_grant[k] = wr_req[k], both combinational. The other client's grants are 0. Memory ports are driven from client k; mem_rd_en = rd_grant[k], mem_wr_en = wr_grant[k] when the coordinate is in range.
- Address = y*IMG_WIDTH + x, computed in ADDR_BITS with no truncation of in-range values.
- Out of range (x ≥ IMG_WIDTH or y ≥ IMG_HEIGHT):
  - The request is still granted and the memory enable is suppressed.
  - A read returns rd_valid with rd_data = 0.
  - addr_err sets and stays set until reset.
- Release OWNk → IDLE when either:
  - client k is not active, or
  - lock[k] = 0, the other client is active, and the hold counter reaches MAX_BURST.
- The hold counter clears on entry to OWNk. While lock[k] = 1, ownership never times out.
- Read return: rd_valid[k] and rd_data[k] are registered one cycle after rd_grant[k], tagged to k, and are delivered even if ownership has moved. rd_data of the non-returning client is 0.
- Bypass: if mem_wr_en and mem_rd_en target the same address in the same cycle, the next-cycle rd_data equals that cycle's mem_wr_data, not mem_rd_data.
- Requesters hold req and coord stable until granted.

## Timing
- Reset values:
  - State IDLE, rr = 0, hold counter 0.
  - All grants, rd_valid, owner, mem_rd_en, mem_wr_en and addr_err are 0.
  - All data and address outputs are 0.
  - Pending read returns are discarded.
- Arbitration latency: a request first seen in IDLE at cycle t is granted at t+1. Back-to-back requests while owning are granted every cycle.
- Read latency: grant at t → rd_valid at t+1.
- Release costs one IDLE cycle. The handover sequence is OWN0 → IDLE → OWN1, giving a minimum 2-cycle gap between clients.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronously). The in-flight rd_valid is not produced.

## Test plan
- Single read: client 0 rd_req at {y=2,x=3} with IMG_WIDTH=32 → grant 1 cycle later, mem_rd_addr=67, rd_valid[0] the following cycle with the RAM word.
- Simultaneous first requests from both clients after reset → client 0 owns first. After client 0 releases, client 1 owns. On the next tie, client 1 wins.
- Client 0 holds lock=1 for 40 cycles with client 1 requesting → no timeout, client 1 waits. With lock=0 and continuous requests, client 0 releases after 16 cycles and client 1 is granted 2 cycles later.
- Write 0xA5A5A5A5 and read the same address in one cycle → rd_data = 0xA5A5A5A5.
- Read {y=0,x=32} → rd_valid with rd_data=0, mem_rd_en=0, addr_err=1 held until reset.
- Reset pulsed during a granted read → no rd_valid, state IDLE, all outputs 0. A new request is granted normally afterward.
